// File: rtl/sample_decim_pkg.sv
// Shared types and constants for the sample_decim decimating sampler.
package sample_decim_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic MODE_PICK = 1'b0;
    localparam logic MODE_ACC  = 1'b1;

    // Wide enough to hold the sum of 2^cnt_w full-scale samples without wrapping.
    function automatic int unsigned acc_width(input int unsigned width, input int unsigned cnt_w);
        return width + cnt_w;
    endfunction

endpackage

// File: rtl/sample_decim_acc.sv
// Per-channel window accumulator with a saturating output sum.
// Built by sample_decim only when SAMPLE_DECIM_ACC_EN is defined.
module sample_decim_acc
    import sample_decim_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             add_i,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             sat_o
);

    localparam int unsigned AW = acc_width(WIDTH, CNT_W);

    logic [AW-1:0] acc_q;
    logic [AW-1:0] acc_d;
    logic [AW-1:0] total;

    // total includes the current sample so the capture edge sees all R samples
    assign total = acc_q + AW'(in_i);
    assign sat_o = |total[AW-1:WIDTH];
    assign sum_o = sat_o ? '1 : total[WIDTH-1:0];

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (add_i) begin
            acc_d = total;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/sample_decim.sv
// Multi-channel decimating sampler: captures one word per channel every div+1 edges.
// Define SAMPLE_DECIM_ACC_EN to build the accumulate mode and the sat flag.
module sample_decim
    import sample_decim_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CH    = 2,
    parameter int unsigned CNT_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                sync,
    input  logic [CNT_W-1:0]    div,
    input  logic                mode,
    input  logic [CH*WIDTH-1:0] in,
    output logic [CH*WIDTH-1:0] out,
    output logic                out_vld,
    output logic                sat
);

    state_e              state_q;
    logic [CNT_W-1:0]    ph_q;
    logic [CNT_W-1:0]    div_q;
    logic [CH*WIDTH-1:0] out_q;
    logic                vld_q;
    logic [CH*WIDTH-1:0] out_d;

`ifdef SAMPLE_DECIM_ACC_EN
    logic                mode_q;
    logic                sat_q;
    logic                sat_d;
    logic [CH*WIDTH-1:0] acc_sum;
    logic [CH-1:0]       acc_sat;
    logic                acc_clr;
    logic                acc_add;

    // Clear whenever this edge does not continue the current window.
    assign acc_clr = (state_q != ST_RUN) || !en || sync || (ph_q == div_q);
    assign acc_add = (mode_q == MODE_ACC);

    for (genvar c = 0; c < CH; c++) begin : g_ch
        sample_decim_acc #(
            .WIDTH(WIDTH),
            .CNT_W(CNT_W)
        ) u_acc (
            .clk_i (clk),
            .rst_ni(rst),
            .clr_i (acc_clr),
            .add_i (acc_add),
            .in_i  (in[c*WIDTH +: WIDTH]),
            .sum_o (acc_sum[c*WIDTH +: WIDTH]),
            .sat_o (acc_sat[c])
        );
    end

    always_comb begin
        out_d = in;
        sat_d = 1'b0;
        if (mode_q == MODE_ACC) begin
            out_d = acc_sum;
            sat_d = |acc_sat;
        end
    end

    assign sat = sat_q;
`else
    logic unused_mode;

    assign unused_mode = mode;
    assign sat         = 1'b0;

    always_comb begin
        out_d = in;
    end
`endif

    assign out     = out_q;
    assign out_vld = vld_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ph_q    <= '0;
            div_q   <= '0;
            out_q   <= '0;
            vld_q   <= 1'b0;
`ifdef SAMPLE_DECIM_ACC_EN
            mode_q  <= MODE_PICK;
            sat_q   <= 1'b0;
`endif
        end else begin
            vld_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (en) begin
                        state_q <= ST_RUN;
                        ph_q    <= '0;
                        div_q   <= div;
`ifdef SAMPLE_DECIM_ACC_EN
                        mode_q  <= mode;
`endif
                    end
                end
                ST_RUN: begin
                    // Priority: disable, then restart, then capture, then advance.
                    if (!en) begin
                        state_q <= ST_IDLE;
                        ph_q    <= '0;
                    end else if (sync) begin
                        ph_q    <= '0;
                        div_q   <= div;
`ifdef SAMPLE_DECIM_ACC_EN
                        mode_q  <= mode;
`endif
                    end else if (ph_q == div_q) begin
                        out_q   <= out_d;
                        vld_q   <= 1'b1;
                        ph_q    <= '0;
                        div_q   <= div;
`ifdef SAMPLE_DECIM_ACC_EN
                        sat_q   <= sat_d;
                        mode_q  <= mode;
`endif
                    end else begin
                        ph_q    <= ph_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
